// File: rtl/seq_fixmul_if.sv
// Request/response bundle for the sequential Q16.16 multiplier.
interface seq_fixmul_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] product;
    logic        ready;
    logic        busy;
    logic        overflow;

    modport master (
        output start, multiplicand, multiplier,
        input  product, ready, busy, overflow
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, ready, busy, overflow
    );
endinterface

// File: rtl/seq_fixmul.sv
// Shift-and-add unsigned Q16.16 multiplier, one multiplier bit per clock.
// Define FIXMUL_SAT_EN to clamp the product to all-ones on overflow.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | 32 shift-and-add steps, busy=1
// DONE  | result registered, ready=1 for one cycle; start here restarts
module seq_fixmul (
    input  logic        clk,
    input  logic        rstn,
    seq_fixmul_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplr;
    logic [4:0]  cnt;
    logic [31:0] product_r;
    logic        ready_r;
    logic        busy_r;
    logic        overflow_r;

    logic [63:0] acc_sum;
    logic        acc_ovf;
    logic [31:0] prod_next;

    // Sum including the current bit, so the last RUN step can register the result directly.
    always_comb begin
        acc_sum = acc + (mplr[0] ? mcand : 64'd0);
        acc_ovf = |acc_sum[63:48];
`ifdef FIXMUL_SAT_EN
        prod_next = acc_ovf ? 32'hFFFF_FFFF : acc_sum[47:16];
`else
        prod_next = acc_sum[47:16];
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= 64'd0;
            mcand      <= 64'd0;
            mplr       <= 32'd0;
            cnt        <= 5'd0;
            product_r  <= 32'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ready_r <= 1'b0;
                    if (bus.start) begin
                        mcand  <= {32'd0, bus.multiplicand};
                        mplr   <= bus.multiplier;
                        acc    <= 64'd0;
                        cnt    <= 5'd0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        product_r  <= prod_next;
                        overflow_r <= acc_ovf;
                        ready_r    <= 1'b1;
                        busy_r     <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.product  = product_r;
    assign bus.ready    = ready_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_seq_fixmul.sv
// Scoreboard bench for seq_fixmul: random and directed operands against a plain 64-bit multiply model.
module tb_seq_fixmul;
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [31:0] prod;
        logic        ovf;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];

    seq_fixmul_if bus();

    seq_fixmul dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int at);
        exp_t        e;
        logic [63:0] full;
        full     = 64'(a) * 64'(b);
        e.ovf    = (full >> 48) != 64'd0;
        e.prod   = full[47:16];
`ifdef FIXMUL_SAT_EN
        if (e.ovf) e.prod = 32'hFFFF_FFFF;
`endif
        e.at_cyc = at;
        return e;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(bus.product), 64'(e.prod));
                check("overflow", 64'(bus.overflow), 64'(e.ovf));
                check("latency_cycle", 64'(cyc), 64'(e.at_cyc));
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noise);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        @(posedge clk); #1;
        sb.push_back(model(a, b, cyc + 32));
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0 || i == 31) check("busy_in_run", 64'(bus.busy), 64'd1);
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.multiplicand = $urandom;
                bus.multiplier = $urandom;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_in_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        logic [31:0] a, b;
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.multiplicand = 32'd0;
        bus.multiplier = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", 64'(bus.product), 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed values with hand-known results.
        run_op(32'h0002_0000, 32'h0003_0000, 1'b0);
        run_op(32'h0001_8000, 32'h0000_8000, 1'b0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op(32'h0100_0000, 32'h0100_0000, 1'b0);
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drain();

        // Start with different operands mid-run must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'h0002_0000;
        bus.multiplier = 32'h0003_0000;
        @(posedge clk); #1;
        sb.push_back(model(32'h0002_0000, 32'h0003_0000, cyc + 32));
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'h0005_0000;
        bus.multiplier = 32'h0005_0000;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Random operands, with random start noise and operand churn while busy.
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 24);
            if (n % 5 == 0) a = a >> 16;
            run_op(a, b, n[0]);
        end
        drain();

        // Start held high: back-to-back operations 33 cycles apart.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'h0002_0000;
        bus.multiplier = 32'h0003_0000;
        @(posedge clk); #1;
        sb.push_back(model(32'h0002_0000, 32'h0003_0000, cyc + 32));
        bus.multiplicand = 32'h0004_0000;
        bus.multiplier = 32'h0000_4000;
        repeat (33) @(posedge clk);
        #1;
        sb.push_back(model(32'h0004_0000, 32'h0000_4000, cyc + 32));
        bus.start = 1'b0;
        drain();

        // Reset mid-operation abandons it; the next start is taken on the first edge after release.
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'h0002_0000;
        bus.multiplier = 32'h0003_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_product", 64'(bus.product), 64'd0);
        check("midrst_ready", 64'(bus.ready), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_overflow", 64'(bus.overflow), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.start = 1'b1;
        bus.multiplicand = 32'h0001_0000;
        bus.multiplier = 32'h0001_0000;
        @(posedge clk); #1;
        sb.push_back(model(32'h0001_0000, 32'h0001_0000, cyc + 32));
        bus.start = 1'b0;
        check("post_rst_busy", 64'(bus.busy), 64'd1);
        drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
